// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter.
// The optional illegal-op check is enabled by defining ALU_ILLEGAL_OP_CHK_EN.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  // Codes the ALU does not implement.
  function automatic logic is_illegal_op(logic [2:0] op);
    return (op == 3'b100) || (op == 3'b110) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or above rr_ptr, wrapping to index 0.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_req
);

  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] req_hi;
  logic            found;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      hi_mask[i] = (i >= int'(rr_ptr));
    end
    req_hi  = req & hi_mask;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    any_req = |req;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_hi[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
        found   = 1'b1;
      end
    end
    // Nothing at or above the pointer: the lowest set request is the wrapped winner.
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one single-cycle ALU between NREQ valid/ready requesters with round-robin grant.
// Define ALU_ILLEGAL_OP_CHK_EN to reject unimplemented op codes and add the rsp_err output.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ALU_W-1:0] req_a,
  input  logic [NREQ*ALU_W-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [ALU_W-1:0]      rsp_result,
  output logic                  rsp_zero,
`ifdef ALU_ILLEGAL_OP_CHK_EN
  output logic                  rsp_err,
`endif
  output logic [ALU_W-1:0]      alu_srca,
  output logic [ALU_W-1:0]      alu_srcb,
  output logic [2:0]            alu_ctrl,
  input  logic [ALU_W-1:0]      alu_result,
  input  logic                  alu_zero
);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [ALU_W-1:0] a_q, a_d;
  logic [ALU_W-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [ALU_W-1:0] res_q, res_d;
  logic             zero_q, zero_d;
`ifdef ALU_ILLEGAL_OP_CHK_EN
  logic             err_q, err_d;
`endif

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any_req;
  logic [IDW-1:0]   ptr_next;
  logic [ALU_W-1:0] sel_a;
  logic [ALU_W-1:0] sel_b;
  logic [2:0]       sel_op;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[ALU_W*i +: ALU_W];
        sel_b  = req_b[ALU_W*i +: ALU_W];
        sel_op = req_op[3*i +: 3];
      end
    end
    ptr_next = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (state_q == RESP) && (gid_q == IDW'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gid_d     = gid_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    zero_d    = zero_q;
`ifdef ALU_ILLEGAL_OP_CHK_EN
    err_d     = err_q;
`endif
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        // Gated by reset so a requester never sees ready while the block is held in reset.
        req_ready = gnt & {NREQ{reset_n}};
        if (any_req) begin
          gid_d    = gnt_idx;
          rr_ptr_d = ptr_next;
`ifdef ALU_ILLEGAL_OP_CHK_EN
          if (is_illegal_op(sel_op)) begin
            // ALU inputs are left untouched; the response is synthesized directly.
            res_d   = '0;
            zero_d  = 1'b1;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            a_d     = sel_a;
            b_d     = sel_b;
            op_d    = sel_op;
            err_d   = 1'b0;
            state_d = EXEC;
          end
`else
          a_d     = sel_a;
          b_d     = sel_b;
          op_d    = sel_op;
          state_d = EXEC;
`endif
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (|(rsp_valid & rsp_ready)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_ILLEGAL_OP_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
`ifdef ALU_ILLEGAL_OP_CHK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign alu_srca   = a_q;
  assign alu_srcb   = b_q;
  assign alu_ctrl   = op_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
`ifdef ALU_ILLEGAL_OP_CHK_EN
  assign rsp_err    = err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NREQ=2) with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned NREQ = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a = '0;
  logic [NREQ*32-1:0] req_b = '0;
  logic [NREQ*3-1:0] req_op = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [31:0]       rsp_result;
  logic              rsp_zero;
`ifdef ALU_ILLEGAL_OP_CHK_EN
  logic              rsp_err;
`endif
  logic [31:0]       alu_srca, alu_srcb, alu_result;
  logic [2:0]        alu_ctrl;
  logic              alu_zero;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ptr = 0;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
`ifdef ALU_ILLEGAL_OP_CHK_EN
    .rsp_err    (rsp_err),
`endif
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared single-cycle ALU.
  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_result = alu_srca + alu_srcb;
      ALU_SUB: alu_result = alu_srca - alu_srcb;
      ALU_AND: alu_result = alu_srca & alu_srcb;
      ALU_OR:  alu_result = alu_srca | alu_srcb;
      ALU_SLT: alu_result = {31'b0, $signed(alu_srca) < $signed(alu_srcb)};
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  function automatic logic [1:0] oh(int id);
    return (id >= 0) ? 2'(1 << id) : 2'b00;
  endfunction

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_op[3*id +: 3]  = op;
  endtask

  task automatic sb_pop(output exp_t e, output bit ok);
    ok = (sb.size() > 0);
    if (ok) e = sb.pop_front();
    else e = '{id: -1, res: '0, zero: 1'b0, err: 1'b0};
  endtask

  // Entered just after a clock edge; returns on a falling edge with rsp_valid set or on timeout.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (rsp_valid == '0 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #7;
    checks++;
    if ({req_ready, rsp_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_handshake: got ready=%b valid=%b exp 00 00", req_ready, rsp_valid);
    end
    checks++;
    if ({rsp_result, rsp_zero} !== 33'b0) begin
      errors++;
      $display("FAIL reset_rsp: got res=%h zero=%b exp 0 0", rsp_result, rsp_zero);
    end
    checks++;
    if ({alu_srca, alu_srcb, alu_ctrl} !== 67'b0) begin
      errors++;
      $display("FAIL reset_alu: got a=%h b=%h ctrl=%b exp 0", alu_srca, alu_srcb, alu_ctrl);
    end
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives one request from a single requester and checks grant, latency and response.
  task automatic test_single_op;
    int   cyc;
    exp_t e;
    bit   ok;
    set_req(0, 32'd5, 32'd3, ALU_ADD);
    req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b exp 01", req_ready);
    end
    sb.push_back('{id: 0, res: 32'd8, zero: 1'b0, err: 1'b0});
    exp_ptr = 1;
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL single_latency: got %0d exp 1", cyc);
    end
    sb_pop(e, ok);
    checks++;
    if (!ok || rsp_valid !== oh(e.id) || rsp_result !== e.res || rsp_zero !== e.zero) begin
      errors++;
      $display("FAIL single_rsp: got v=%b res=%h z=%b exp v=%b res=%h z=%b",
               rsp_valid, rsp_result, rsp_zero, oh(e.id), e.res, e.zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_zero;
    int   cyc;
    exp_t e;
    bit   ok;
    set_req(1, 32'h1234, 32'h1234, ALU_SUB);
    req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL sub_ready: got %b exp 10", req_ready);
    end
    sb.push_back('{id: 1, res: 32'd0, zero: 1'b1, err: 1'b0});
    exp_ptr = 0;
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(cyc);
    sb_pop(e, ok);
    checks++;
    if (!ok || cyc != 1 || rsp_valid !== oh(e.id) || rsp_result !== e.res ||
        rsp_zero !== e.zero) begin
      errors++;
      $display("FAIL sub_rsp: got cyc=%0d v=%b res=%h z=%b exp cyc=1 v=%b res=%h z=%b",
               cyc, rsp_valid, rsp_result, rsp_zero, oh(e.id), e.res, e.zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention;
    int   cyc;
    int   g;
    exp_t e;
    bit   ok;
    g = exp_ptr;
    set_req(0, 32'hF0, 32'h0F, ALU_OR);
    set_req(1, 32'hF0, 32'h0F, ALU_OR);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== oh(g)) begin
        errors++;
        $display("FAIL contention_grant%0d: got %b exp %b", k, req_ready, oh(g));
      end
      sb.push_back('{id: g, res: 32'hFF, zero: 1'b0, err: 1'b0});
      g = (g + 1) % NREQ;
      @(posedge clk); #1;
      wait_rsp(cyc);
      sb_pop(e, ok);
      checks++;
      if (!ok || cyc != 1 || req_ready !== 2'b00 || rsp_valid !== oh(e.id) ||
          rsp_result !== e.res || rsp_zero !== e.zero) begin
        errors++;
        $display("FAIL contention_rsp%0d: got cyc=%0d rdy=%b v=%b res=%h exp cyc=1 rdy=00 v=%b res=%h",
                 k, cyc, req_ready, rsp_valid, rsp_result, oh(e.id), e.res);
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    exp_ptr = g;
  endtask

  task automatic test_backpressure;
    int   cyc;
    exp_t e;
    bit   ok;
    rsp_ready = 2'b00;
    set_req(0, 32'd7, 32'd9, ALU_ADD);
    req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_ready: got %b exp 01", req_ready);
    end
    sb.push_back('{id: 0, res: 32'd16, zero: 1'b0, err: 1'b0});
    @(posedge clk); #1;
    set_req(1, 32'd100, 32'd1, ALU_SUB);
    req_valid = 2'b10;
    rsp_ready = 2'b10;  // the non-granted requester's ready must not complete the response
    wait_rsp(cyc);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== 32'd16 || req_ready !== 2'b00 ||
          alu_srca !== 32'd7) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b res=%h rdy=%b a=%h exp v=01 res=10 rdy=00 a=7",
                 k, rsp_valid, rsp_result, req_ready, alu_srca);
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    rsp_ready = 2'b11;
    sb_pop(e, ok);
    checks++;
    if (!ok || rsp_valid !== oh(e.id) || rsp_result !== e.res || rsp_zero !== e.zero) begin
      errors++;
      $display("FAIL bp_rsp: got v=%b res=%h exp v=%b res=%h", rsp_valid, rsp_result,
               oh(e.id), e.res);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_next_grant: got %b exp 10", req_ready);
    end
    sb.push_back('{id: 1, res: 32'd99, zero: 1'b0, err: 1'b0});
    exp_ptr = 0;
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(cyc);
    sb_pop(e, ok);
    checks++;
    if (!ok || cyc != 1 || rsp_valid !== oh(e.id) || rsp_result !== e.res) begin
      errors++;
      $display("FAIL bp_rsp2: got cyc=%0d v=%b res=%h exp cyc=1 v=%b res=%h",
               cyc, rsp_valid, rsp_result, oh(e.id), e.res);
    end
    @(posedge clk); #1;
  endtask

  // s=0: only requester 1 valid after reset; s=1: both valid, pointer must be back at 0.
  task automatic test_reset_mid_exec;
    int   cyc;
    int   g;
    exp_t e;
    bit   ok;
    for (int s = 0; s < 2; s++) begin
      set_req(0, 32'hAAAA, 32'd1, ALU_SUB);
      set_req(1, 32'd20, 32'd6, ALU_SUB);
      req_valid = 2'b01;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
        errors++;
        $display("FAIL rst%0d_pre_grant: got %b exp 01", s, req_ready);
      end
      sb.push_back('{id: 0, res: 32'hAAA9, zero: 1'b0, err: 1'b0});
      @(posedge clk); #1;
      req_valid = (s == 0) ? 2'b10 : 2'b11;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, req_ready, rsp_result, rsp_zero, alu_srca, alu_srcb, alu_ctrl} !== '0) begin
        errors++;
        $display("FAIL rst%0d_async: got v=%b rdy=%b res=%h a=%h ctrl=%b exp all 0",
                 s, rsp_valid, req_ready, rsp_result, alu_srca, alu_ctrl);
      end
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      g = (s == 0) ? 1 : 0;
      #1;
      checks++;
      if (req_ready !== oh(g)) begin
        errors++;
        $display("FAIL rst%0d_first_grant: got %b exp %b", s, req_ready, oh(g));
      end
      sb.push_back('{id: g, res: (g == 1) ? 32'd14 : 32'hAAA9, zero: 1'b0, err: 1'b0});
      exp_ptr = (g + 1) % NREQ;
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp(cyc);
      sb_pop(e, ok);
      checks++;
      if (!ok || cyc != 1 || rsp_valid !== oh(e.id) || rsp_result !== e.res) begin
        errors++;
        $display("FAIL rst%0d_rsp: got cyc=%0d v=%b res=%h exp cyc=1 v=%b res=%h",
                 s, cyc, rsp_valid, rsp_result, oh(e.id), e.res);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef ALU_ILLEGAL_OP_CHK_EN
  task automatic test_illegal_op;
    int   cyc;
    exp_t e;
    bit   ok;
    logic [2:0] ctrl_before;
    ctrl_before = alu_ctrl;
    set_req(0, 32'd5, 32'd5, 3'b111);
    req_valid = 2'b01;
    @(negedge clk);
    sb.push_back('{id: 0, res: 32'd0, zero: 1'b1, err: 1'b1});
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(cyc);
    sb_pop(e, ok);
    checks++;
    if (!ok || cyc != 0 || rsp_valid !== oh(e.id) || rsp_result !== e.res ||
        rsp_zero !== e.zero || rsp_err !== e.err || alu_ctrl !== ctrl_before) begin
      errors++;
      $display("FAIL illegal_rsp: got cyc=%0d v=%b res=%h z=%b err=%b ctrl=%b exp cyc=0 v=%b res=%h z=%b err=%b ctrl=%b",
               cyc, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_ctrl, oh(e.id), e.res,
               e.zero, e.err, ctrl_before);
    end
    @(posedge clk); #1;
    set_req(1, 32'd1, 32'd2, ALU_SLT);
    req_valid = 2'b10;
    @(negedge clk);
    sb.push_back('{id: 1, res: 32'd1, zero: 1'b0, err: 1'b0});
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(cyc);
    sb_pop(e, ok);
    checks++;
    if (!ok || cyc != 1 || rsp_valid !== oh(e.id) || rsp_result !== e.res ||
        rsp_err !== e.err) begin
      errors++;
      $display("FAIL slt_rsp: got cyc=%0d v=%b res=%h err=%b exp cyc=1 v=%b res=%h err=%b",
               cyc, rsp_valid, rsp_result, rsp_err, oh(e.id), e.res, e.err);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_sub_zero();
    test_contention();
    test_backpressure();
    test_reset_mid_exec();
`ifdef ALU_ILLEGAL_OP_CHK_EN
    test_illegal_op();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single-cycle 32-bit ALU between NREQ requesters, for example a main datapath port and an address/branch helper.
- Uses a valid/ready handshake on each requester port and a round-robin grant.
- Each accepted operation is sequenced through the ALU and its result is registered.
- The result is returned to the granted requester only.
- Sits between the requesters and the ALU instance, and drives the ALU's SrcA, SrcB and ALUControl inputs.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ) (minimum 1), width of the grant index.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*32  operand A; requester i occupies bits [32i+31:32i].
- req_b  input  NREQ*32  operand B, packed the same way.
- req_op  input  NREQ*3  ALU control code; requester i occupies bits [3i+2:3i].
- rsp_valid  output  NREQ  response valid; one-hot or zero.
- rsp_ready  input  NREQ  response accept.
- rsp_result  output  32  registered ALU result.
- rsp_zero  output  1  registered Zero flag.
- alu_srca  output  32  to ALU SrcA.
- alu_srcb  output  32  to ALU SrcB.
- alu_ctrl  output  3  to ALU ALUControl.
- alu_result  input  32  from ALU ALUResult.
- alu_zero  input  1  from ALU Zero.

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low (reset_n).
- Reset values:
  - State = IDLE.
  - rr_ptr = 0.
  - req_ready = 0, rsp_valid = 0.
  - rsp_result = 0, rsp_zero = 0.
  - Operand registers = 0, which drives alu_srca = alu_srcb = 0 and alu_ctrl = 3'b000.
- IDLE:
  - Grant goes to the first requester i with req_valid set, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[grant] is asserted combinationally in the same cycle; no other req_ready bit is set.
  - On acceptance (valid & ready): capture a/b/op and the grant index, set rr_ptr = grant+1 (wrapping to 0 after NREQ-1), go to EXEC.
  - If no request is valid, stay in IDLE with rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - The ALU is driven from the captured registers.
  - alu_result and alu_zero are sampled into rsp_result and rsp_zero at the end of the cycle, then go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid[grant] = 1, and rsp_result/rsp_zero hold stable until rsp_ready[grant] = 1.
  - Then go to IDLE; the next grant may be accepted in the following cycle.
  - rsp_ready bits of other requesters are ignored.
- Latency:
  - Accept at cycle N, rsp_valid at cycle N+2.
  - Maximum throughput is one operation per 3 cycles.
- ALU inputs change only on the acceptance edge, so the ALU default/hold path never sees a glitching control value.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0.
  - No requester waits more than NREQ-1 other grants.
- Request inputs:
  - Requesters must hold valid, a, b and op stable until accepted.
  - Deasserting valid before acceptance is legal, and the arbiter re-evaluates every IDLE cycle.
- Reset asserted mid-operation: the transaction is dropped, all outputs return to reset values immediately (asynchronously), and rr_ptr returns to 0.

Optional Feature:
- Macro: ALU_ILLEGAL_OP_CHK_EN.
- Defined:
  - Codes 3'b100, 3'b110 and 3'b111 are illegal.
  - On acceptance of an illegal code, the FSM skips the ALU: alu_ctrl keeps its previous value and the FSM goes directly to RESP with rsp_result = 0 and rsp_zero = 1.
  - An extra output rsp_err (1 bit, reset 0) is 1 for that response and 0 for legal ones.
  - Latency for an illegal op is N+1.
- Undefined: all codes are forwarded unchanged, there is no rsp_err port, and latency is always N+2.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_t: ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101.
  - typedef enum logic [1:0] arb_state_t: IDLE, EXEC, RESP.
  - localparam ALU_W = 32.
- One sub-module, rr_arbiter #(NREQ):
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, grant index and any_req.
  - Purely combinational.
  - The FSM, operand registers and pointer update stay in alu_arbiter.

Test Plan:
- Single op: req0 a=5, b=3, op=ADD → req_ready[0] in the same cycle; rsp_valid[0] two cycles later with result 8, zero 0.
- SUB to zero: req1 a=0x1234, b=0x1234, op=SUB → result 0, zero 1, on rsp_valid[1] only.
- Contention:
  - Stimulus: req0 and req1 both continuously valid with op=OR (0xF0 | 0x0F).
  - Required: grants alternate 0,1,0,1; each result is 0xFF; no requester is granted twice in a row.
- Response backpressure: hold rsp_ready=0 for 5 cycles → rsp_result and rsp_valid stay stable, req_ready stays 0, and no new grant occurs until the response is accepted.
- Reset mid-EXEC: assert reset_n=0 during EXEC → rsp_valid=0, rr_ptr=0 and state IDLE without any clock edge; after release, req1 alone is granted first.
- With ALU_ILLEGAL_OP_CHK_EN: op=3'b111 → rsp_valid one cycle after acceptance, result 0, zero 1, rsp_err 1; a following SLT with a=1, b=2 → result 1, rsp_err 0.
